// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART multiplier command controller.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_RX,
    S_CHECK,
    S_MUL_START,
    S_MUL_WAIT,
    S_TX_LOAD,
    S_TX_WAIT
  } state_t;

  localparam logic [7:0] OP_MUL      = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_CSUM     = 8'h01;
  localparam logic [7:0] ST_OPCODE   = 8'h02;
  localparam logic [7:0] ST_TIMEOUT  = 8'h03;

  localparam logic [7:0] SYNC_RX_DEF = 8'hA5;
  localparam logic [7:0] SYNC_TX_DEF = 8'h5A;

  localparam int CMD_LEN = 7;
  localparam int RSP_LEN = 7;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_resp_serializer.sv
// Sends a captured 7-byte response to the UART transmitter, one byte per
// complete busy high/low cycle of the transmitter.
module uart_resp_serializer
  import uart_ctrl_pkg::*;
(
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       load,
  input  logic [7:0] resp [RSP_LEN],
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done,
  output state_t     phase_nx
);

  state_t     phase_q, phase_d;
  logic [2:0] k_q, k_d;
  logic       seen_q, seen_d;
  logic [7:0] buf_q [RSP_LEN];
  logic [7:0] buf_d [RSP_LEN];
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      phase_q    <= S_SYNC;
      k_q        <= 3'd0;
      seen_q     <= 1'b0;
      buf_q      <= '{default: 8'h00};
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      k_q        <= k_d;
      seen_q     <= seen_d;
      buf_q      <= buf_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    k_d        = k_q;
    seen_d     = seen_q;
    buf_d      = buf_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done       = 1'b0;
    if (load) begin
      buf_d   = resp;
      k_d     = 3'd0;
      phase_d = S_TX_LOAD;
    end else begin
      case (phase_q)
        S_TX_LOAD: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = buf_q[k_q];
            seen_d     = 1'b0;
            phase_d    = S_TX_WAIT;
          end
        end
        // busy may lag tx_start by a cycle, so a low busy only counts after a high one
        S_TX_WAIT: begin
          if (tx_busy) begin
            seen_d = 1'b1;
          end else if (seen_q) begin
            if (k_q == 3'(RSP_LEN - 1)) begin
              done    = 1'b1;
              phase_d = S_SYNC;
            end else begin
              k_d     = k_q + 3'd1;
              phase_d = S_TX_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign phase_nx = phase_d;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_mult_ctrl.sv
// Command controller: assembles 7-byte command frames from the UART receiver,
// runs the multiplier and hands a 7-byte response to the serializer.
module uart_mult_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          OP_WIDTH       = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  SYNC_RX        = SYNC_RX_DEF,
  parameter logic [7:0]  SYNC_TX        = SYNC_TX_DEF
) (
  input  logic                  uart_clock,
  input  logic                  uart_reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  mult_start,
  output logic [OP_WIDTH-1:0]   mult_a,
  output logic [OP_WIDTH-1:0]   mult_b,
  input  logic                  mult_done,
  input  logic [2*OP_WIDTH-1:0] mult_product,
  output logic                  busy,
  output logic [7:0]            err_count,
  output logic [7:0]            drop_count
);

  state_t                state_q, state_d;
  logic                  rx_valid_q;
  logic [2:0]            idx_q, idx_d;
  logic [23:0]           timer_q, timer_d;
  logic [7:0]            frame_q [CMD_LEN-1];
  logic [7:0]            frame_d [CMD_LEN-1];
  logic [7:0]            status_q, status_d;
  logic [2*OP_WIDTH-1:0] last_product_q, last_product_d;
  logic [OP_WIDTH-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic                  mult_start_q, mult_start_d;
  logic [7:0]            err_q, err_d, drop_q, drop_d;
  logic                  strobe, ser_load, ser_done;
  logic [7:0]            cs_calc;
  logic [31:0]           p;
  logic [7:0]            resp [RSP_LEN];
  state_t                ser_phase_nx;

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q        <= S_SYNC;
      rx_valid_q     <= 1'b0;
      idx_q          <= 3'd0;
      timer_q        <= 24'd0;
      frame_q        <= '{default: 8'h00};
      status_q       <= ST_OK;
      last_product_q <= '0;
      mult_a_q       <= '0;
      mult_b_q       <= '0;
      mult_start_q   <= 1'b0;
      err_q          <= 8'h00;
      drop_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      rx_valid_q     <= rx_valid;
      idx_q          <= idx_d;
      timer_q        <= timer_d;
      frame_q        <= frame_d;
      status_q       <= status_d;
      last_product_q <= last_product_d;
      mult_a_q       <= mult_a_d;
      mult_b_q       <= mult_b_d;
      mult_start_q   <= mult_start_d;
      err_q          <= err_d;
      drop_q         <= drop_d;
    end
  end

  assign strobe  = rx_valid & ~rx_valid_q;
  assign cs_calc = frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    timer_d        = timer_q;
    frame_d        = frame_q;
    status_d       = status_q;
    last_product_d = last_product_q;
    mult_a_d       = mult_a_q;
    mult_b_d       = mult_b_q;
    mult_start_d   = 1'b0;
    err_d          = err_q;
    drop_d         = drop_q;
    ser_load       = 1'b0;
    if (strobe && state_q != S_SYNC && state_q != S_RX) drop_d = sat_inc(drop_q);
    case (state_q)
      S_SYNC: begin
        if (strobe && rx_data == SYNC_RX) begin
          state_d = S_RX;
          idx_d   = 3'd0;
          timer_d = 24'd0;
        end
      end
      S_RX: begin
        if (strobe) begin
          frame_d[idx_q] = rx_data;
          idx_d          = idx_q + 3'd1;
          timer_d        = 24'd0;
          if (idx_q == 3'd5) state_d = S_CHECK;
        end else if (timer_q == TIMEOUT_CYCLES - 24'd1) begin
          err_d   = sat_inc(err_q);
          state_d = S_SYNC;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      // mult_start is raised here so the pulse lands in S_MUL_START
      S_CHECK: begin
        if (cs_calc != frame_q[5]) begin
          status_d = ST_CSUM;
          err_d    = sat_inc(err_q);
          ser_load = 1'b1;
          state_d  = S_TX_LOAD;
        end else if (frame_q[0] == OP_MUL) begin
          mult_a_d     = OP_WIDTH'({frame_q[1], frame_q[2]});
          mult_b_d     = OP_WIDTH'({frame_q[3], frame_q[4]});
          mult_start_d = 1'b1;
          state_d      = S_MUL_START;
        end else if (frame_q[0] == OP_READ) begin
          status_d = ST_OK;
          ser_load = 1'b1;
          state_d  = S_TX_LOAD;
        end else begin
          status_d = ST_OPCODE;
          err_d    = sat_inc(err_q);
          ser_load = 1'b1;
          state_d  = S_TX_LOAD;
        end
      end
      S_MUL_START: begin
        timer_d = 24'd0;
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mult_done) begin
          last_product_d = mult_product;
          status_d       = ST_OK;
          ser_load       = 1'b1;
          state_d        = S_TX_LOAD;
        end else if (timer_q == TIMEOUT_CYCLES - 24'd1) begin
          status_d = ST_TIMEOUT;
          err_d    = sat_inc(err_q);
          ser_load = 1'b1;
          state_d  = S_TX_LOAD;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_TX_LOAD, S_TX_WAIT: state_d = ser_done ? S_SYNC : ser_phase_nx;
      default: state_d = S_SYNC;
    endcase
  end

  // Response is built from next-state values so the load cycle sees fresh status/product
  always_comb begin
    p       = (status_d == ST_OK) ? 32'(last_product_d) : 32'd0;
    resp[0] = SYNC_TX;
    resp[1] = status_d;
    resp[2] = p[31:24];
    resp[3] = p[23:16];
    resp[4] = p[15:8];
    resp[5] = p[7:0];
    resp[6] = status_d ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  end

  uart_resp_serializer u_ser (
    .uart_clock (uart_clock),
    .uart_reset (uart_reset),
    .load       (ser_load),
    .resp       (resp),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .done       (ser_done),
    .phase_nx   (ser_phase_nx)
  );

  assign mult_start = mult_start_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign busy       = (state_q != S_SYNC);
  assign err_count  = err_q;
  assign drop_count = drop_q;

endmodule
